hd44780_lcd_responder: RTL
==========================

Name: hd44780_lcd_responder

Overview:
- Synthesizable model of the HD44780 side of the 4-bit LCD bus: the receiving end of the controller's rs/e/nybble pins.
- Tracks the power-on 8-bit mode and the switch to 4-bit mode, and reassembles nybble pairs into bytes.
- Decodes the cursor-affecting commands, writes data bytes into a DDRAM shadow port, and flags bus protocol and timing violations.
- Used as the bench and hardware-loopback target for the controller, and as a capture source for self-checking tests.

Parameters:
- E_MIN_HIGH, 3: minimum e high width in CLK_I cycles; a shorter pulse is a timing error.
- BUSY_CLKS, 40: busy time after any non-clear/home instruction or data write.
- CLEAR_BUSY_CLKS, 1600: busy time after clear (0x01) or home (0x02/0x03).
- DDRAM_AWIDTH, 7: width of the cursor/DDRAM address.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  reset; synchronous, active-low.
- i_rs  in  1  LCD register select (0 = instruction, 1 = data).
- i_e  in  1  LCD enable; data is captured on its falling edge.
- i_lcd_nybble  in  4  LCD D7..D4.
- o_valid  out  1  one-cycle pulse: o_byte/o_byte_rs are valid.
- o_byte  out  8  reassembled byte.
- o_byte_rs  out  1  rs of the byte (rs of the high nybble).
- o_ddram_we  out  1  one-cycle DDRAM write strobe.
- o_ddram_addr  out  DDRAM_AWIDTH  write address.
- o_ddram_data  out  8  write data.
- o_clear  out  1  one-cycle pulse on the clear-display command.
- o_four_bit  out  1  high once 4-bit mode is active.
- o_busy  out  1  modelled busy flag.
- o_error  out  1  sticky protocol/timing error.

Behaviour:
- Reset (RST_I low at a posedge):
  - all outputs 0; internal mode = 8-bit; nybble phase = HIGH; cursor addr = 0; increment = 1; busy counter = 0; e-high counter = 0; previous-e sample = 0.
  - Reset mid-byte discards any held high nybble.
- Sampling:
  - i_e/i_rs/i_lcd_nybble are sampled every posedge.
  - Fall = sampled e 0 and previous sample 1. Rise = the converse.
- E-width check: at fall, if the e-high count < E_MIN_HIGH, set o_error. The nybble is still accepted.
- Busy check:
  - Busy counter loads on instruction completion and decrements to 0 each cycle; o_busy = (counter != 0).
  - A rise while o_busy is high sets o_error. The transfer is still processed.
- States: MODE8, MODE4_HI, MODE4_LO.
- MODE8:
  - Each fall is a complete instruction; its byte is {nybble, 4'h0}.
  - The byte emits o_valid and loads BUSY_CLKS.
  - Byte 0x20 with rs = 0 → MODE4_HI and o_four_bit = 1.
  - Any rs = 1 transfer in MODE8 sets o_error and is not written.
- MODE4_HI: fall latches nybble and rs → MODE4_LO.
- MODE4_LO:
  - Fall forms byte {hi, lo}, then processes it → MODE4_HI.
  - If rs differs from the held rs, set o_error; the byte uses the high nybble's rs.
- Output timing:
  - o_valid is registered, high exactly 1 cycle, at posedge F+1, where F is the posedge that samples the completing fall.
  - o_ddram_we, o_clear and the busy load share that cycle.
- Byte processing, rs = 0:
  - 0x01: addr = 0, increment = 1, o_clear pulse, load CLEAR_BUSY_CLKS.
  - 0x02/0x03: addr = 0, load CLEAR_BUSY_CLKS.
  - 0x04–0x07: increment = bit1.
  - 0x20–0x3F: if bit4 (DL) = 1, return to MODE8 and set o_four_bit = 0.
  - 0x80–0xFF: addr = byte[DDRAM_AWIDTH-1:0].
  - Others: no state change.
  - All instructions except clear/home load BUSY_CLKS.
- Byte processing, rs = 1:
  - o_ddram_we with o_ddram_addr = current addr and o_ddram_data = byte.
  - addr ± 1 modulo 2^DDRAM_AWIDTH: 0x7F + 1 → 0x00; 0x00 − 1 → 0x7F.
  - Load BUSY_CLKS.
- Simultaneous events: a fall occurring while the busy counter is nonzero is processed normally; the new busy load replaces the remaining count.
- o_error clears only on reset.

Optional Feature:
- HD44780_RESPONDER_SYNC_EN defined: i_e, i_rs and i_lcd_nybble each pass through a 2-flop synchronizer before sampling. All response latencies grow by 2 cycles (o_valid at F+3 relative to the raw pin posedge).
- Undefined: pins are sampled directly, as specified above.

Test Plan:
- Init: single nybbles 3, 3, 3, 2 (rs = 0, e high 5 cycles, gaps ≥ 45 cycles) → four o_valid pulses with o_byte 0x30, 0x30, 0x30, 0x20; o_four_bit = 1 after the 4th; o_error = 0.
- Write pair: after init, send 0x80|0x45 then data nybbles 4, 1 (rs = 1) → o_ddram_we with addr 0x45, data 0x41; next data write lands at 0x46.
- Entry mode and wrap:
  - 0x04 (decrement), set addr 0x00, write 0x5A → we at 0x00; the next write lands at 0x7F.
  - 0x06, set addr 0x7F, write two bytes → addresses 0x7F then 0x00.
- Clear: 0x01 → o_clear pulse, o_busy high for 1600 cycles; an e rise at cycle 100 after the clear sets o_error; a rise at cycle 1601 does not.
- Short enable: e high 2 cycles (E_MIN_HIGH = 3) → nybble still captured, o_error = 1 and stays 1 until RST_I low.
- Reset mid-byte: high nybble sent, RST_I low 1 cycle → mode back to MODE8, o_four_bit = 0, no o_valid; the next nybble 0x3 yields o_byte 0x30.

Source files
------------

// File: rtl/hd44780_lcd_responder.sv
// HD44780 side of the 4-bit LCD bus: reassembles nybbles, tracks cursor/DDRAM writes, flags protocol errors.
// Define HD44780_RESPONDER_SYNC_EN to put 2-flop synchronizers on i_e/i_rs/i_lcd_nybble.
module hd44780_lcd_responder #(
    parameter int unsigned E_MIN_HIGH      = 3,
    parameter int unsigned BUSY_CLKS       = 40,
    parameter int unsigned CLEAR_BUSY_CLKS = 1600,
    parameter int unsigned DDRAM_AWIDTH    = 7
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    i_rs,
    input  logic                    i_e,
    input  logic [3:0]              i_lcd_nybble,
    output logic                    o_valid,
    output logic [7:0]              o_byte,
    output logic                    o_byte_rs,
    output logic                    o_ddram_we,
    output logic [DDRAM_AWIDTH-1:0] o_ddram_addr,
    output logic [7:0]              o_ddram_data,
    output logic                    o_clear,
    output logic                    o_four_bit,
    output logic                    o_busy,
    output logic                    o_error
);

    localparam int unsigned BMAX = (CLEAR_BUSY_CLKS > BUSY_CLKS) ? CLEAR_BUSY_CLKS : BUSY_CLKS;
    localparam int unsigned BW   = $clog2(BMAX + 1);
    localparam int unsigned EW   = $clog2(E_MIN_HIGH + 2);
    localparam int unsigned AW   = DDRAM_AWIDTH;

    typedef enum logic [1:0] {MODE8, MODE4_HI, MODE4_LO} state_t;

    logic       e_in, rs_in;
    logic [3:0] nyb_in;

`ifdef HD44780_RESPONDER_SYNC_EN
    logic       e_s1_q, e_s2_q, rs_s1_q, rs_s2_q;
    logic [3:0] nyb_s1_q, nyb_s2_q;

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            e_s1_q   <= 1'b0;
            e_s2_q   <= 1'b0;
            rs_s1_q  <= 1'b0;
            rs_s2_q  <= 1'b0;
            nyb_s1_q <= '0;
            nyb_s2_q <= '0;
        end else begin
            e_s1_q   <= i_e;
            e_s2_q   <= e_s1_q;
            rs_s1_q  <= i_rs;
            rs_s2_q  <= rs_s1_q;
            nyb_s1_q <= i_lcd_nybble;
            nyb_s2_q <= nyb_s1_q;
        end
    end

    assign e_in   = e_s2_q;
    assign rs_in  = rs_s2_q;
    assign nyb_in = nyb_s2_q;
`else
    assign e_in   = i_e;
    assign rs_in  = i_rs;
    assign nyb_in = i_lcd_nybble;
`endif

    state_t        state_q, state_d;
    logic          e_s_q, e_s_d, e_prev_q, e_prev_d, rs_s_q, rs_s_d;
    logic [3:0]    nyb_s_q, nyb_s_d, hi_nyb_q, hi_nyb_d;
    logic          hi_rs_q, hi_rs_d, inc_q, inc_d;
    logic [AW-1:0] addr_q, addr_d, ddram_addr_q, ddram_addr_d;
    logic [BW-1:0] busy_cnt_q, busy_cnt_d;
    logic [EW-1:0] ehi_cnt_q, ehi_cnt_d;
    logic          valid_q, valid_d, byte_rs_q, byte_rs_d, we_q, we_d;
    logic          clear_q, clear_d, four_bit_q, four_bit_d, error_q, error_d;
    logic [7:0]    byte_q, byte_d, ddram_data_q, ddram_data_d;
    logic          fall, rise, proc;
    logic [7:0]    pbyte;
    logic          prs;

    always_comb begin
        state_d      = state_q;
        e_s_d        = e_in;
        e_prev_d     = e_s_q;
        rs_s_d       = rs_in;
        nyb_s_d      = nyb_in;
        hi_nyb_d     = hi_nyb_q;
        hi_rs_d      = hi_rs_q;
        inc_d        = inc_q;
        addr_d       = addr_q;
        ddram_addr_d = ddram_addr_q;
        ddram_data_d = ddram_data_q;
        byte_d       = byte_q;
        byte_rs_d    = byte_rs_q;
        four_bit_d   = four_bit_q;
        error_d      = error_q;
        valid_d      = 1'b0;
        we_d         = 1'b0;
        clear_d      = 1'b0;
        proc         = 1'b0;
        pbyte        = '0;
        prs          = 1'b0;
        fall         = !e_s_q && e_prev_q;
        rise         = e_s_q && !e_prev_q;
        busy_cnt_d   = (busy_cnt_q != '0) ? busy_cnt_q - BW'(1) : '0;
        ehi_cnt_d    = ehi_cnt_q;

        // Count sampled-high cycles since the rise, saturating.
        if (e_s_q)
            ehi_cnt_d = rise ? EW'(1) : ((ehi_cnt_q == '1) ? ehi_cnt_q : ehi_cnt_q + EW'(1));
        if (rise && busy_cnt_q != '0)
            error_d = 1'b1;

        if (fall) begin
            if (ehi_cnt_q < EW'(E_MIN_HIGH))
                error_d = 1'b1;
            unique case (state_q)
                MODE8: begin
                    if (rs_s_q) begin
                        error_d = 1'b1;
                    end else begin
                        proc  = 1'b1;
                        pbyte = {nyb_s_q, 4'h0};
                    end
                end
                MODE4_HI: begin
                    hi_nyb_d = nyb_s_q;
                    hi_rs_d  = rs_s_q;
                    state_d  = MODE4_LO;
                end
                default: begin
                    if (rs_s_q != hi_rs_q)
                        error_d = 1'b1;
                    proc    = 1'b1;
                    pbyte   = {hi_nyb_q, nyb_s_q};
                    prs     = hi_rs_q;
                    state_d = MODE4_HI;
                end
            endcase
        end

        if (proc) begin
            valid_d    = 1'b1;
            byte_d     = pbyte;
            byte_rs_d  = prs;
            busy_cnt_d = BW'(BUSY_CLKS);
            if (prs) begin
                we_d         = 1'b1;
                ddram_addr_d = addr_q;
                ddram_data_d = pbyte;
                addr_d       = inc_q ? addr_q + AW'(1) : addr_q - AW'(1);
            end else if (pbyte == 8'h01) begin
                addr_d     = '0;
                inc_d      = 1'b1;
                clear_d    = 1'b1;
                busy_cnt_d = BW'(CLEAR_BUSY_CLKS);
            end else if (pbyte[7:1] == 7'h01) begin
                addr_d     = '0;
                busy_cnt_d = BW'(CLEAR_BUSY_CLKS);
            end else if (pbyte[7:2] == 6'h01) begin
                inc_d = pbyte[1];
            end else if (pbyte[7:5] == 3'b001) begin
                // Function set: DL=1 always returns to 8-bit; DL=0 only switches from 8-bit.
                if (pbyte[4]) begin
                    state_d    = MODE8;
                    four_bit_d = 1'b0;
                end else if (state_q == MODE8) begin
                    state_d    = MODE4_HI;
                    four_bit_d = 1'b1;
                end
            end else if (pbyte[7]) begin
                addr_d = pbyte[AW-1:0];
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q      <= MODE8;
            e_s_q        <= 1'b0;
            e_prev_q     <= 1'b0;
            rs_s_q       <= 1'b0;
            nyb_s_q      <= '0;
            hi_nyb_q     <= '0;
            hi_rs_q      <= 1'b0;
            inc_q        <= 1'b1;
            addr_q       <= '0;
            busy_cnt_q   <= '0;
            ehi_cnt_q    <= '0;
            valid_q      <= 1'b0;
            byte_q       <= '0;
            byte_rs_q    <= 1'b0;
            we_q         <= 1'b0;
            ddram_addr_q <= '0;
            ddram_data_q <= '0;
            clear_q      <= 1'b0;
            four_bit_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_s_q        <= e_s_d;
            e_prev_q     <= e_prev_d;
            rs_s_q       <= rs_s_d;
            nyb_s_q      <= nyb_s_d;
            hi_nyb_q     <= hi_nyb_d;
            hi_rs_q      <= hi_rs_d;
            inc_q        <= inc_d;
            addr_q       <= addr_d;
            busy_cnt_q   <= busy_cnt_d;
            ehi_cnt_q    <= ehi_cnt_d;
            valid_q      <= valid_d;
            byte_q       <= byte_d;
            byte_rs_q    <= byte_rs_d;
            we_q         <= we_d;
            ddram_addr_q <= ddram_addr_d;
            ddram_data_q <= ddram_data_d;
            clear_q      <= clear_d;
            four_bit_q   <= four_bit_d;
            error_q      <= error_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_byte       = byte_q;
    assign o_byte_rs    = byte_rs_q;
    assign o_ddram_we   = we_q;
    assign o_ddram_addr = ddram_addr_q;
    assign o_ddram_data = ddram_data_q;
    assign o_clear      = clear_q;
    assign o_four_bit   = four_bit_q;
    assign o_busy       = (busy_cnt_q != '0);
    assign o_error      = error_q;

endmodule
